// File: rtl/vga_rx_pkg.sv
// Shared types and default 640x480 timing for the VGA receive path.
package vga_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        LOCKED
    } rxState_t;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t COUNT_MAX = '1;

    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_H_START     = 144;
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_V_START     = 35;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_LOCK_FRAMES = 2;

endpackage

// File: rtl/vga_period_counter.sv
// Saturating period counter: clears on a boundary event, increments otherwise,
// and flags when the period that just ended differs from the expected length.
module vga_period_counter
    import vga_rx_pkg::*;
#(
    parameter int PERIOD = 800
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                i_inc,
    input  logic                i_clear,
    output logic [COORD_W-1:0]  o_count,
    output logic                o_mismatch,
    output logic                o_sat
);

    localparam logic [COORD_W:0] PERIOD_W = (COORD_W+1)'(PERIOD);

    coord_t r_count;
    coord_t w_next;
    logic   w_atMax;

    assign w_atMax = (r_count == COUNT_MAX);

    // o_count is the value that belongs to the current event, so downstream
    // logic sees 0 on the clearing strobe itself.
    assign w_next     = i_clear ? '0 :
                        (i_inc && !w_atMax) ? r_count + coord_t'(1) : r_count;
    assign o_count    = w_next;
    assign o_mismatch = i_clear && (({1'b0, r_count} + (COORD_W+1)'(1)) != PERIOD_W);
    assign o_sat      = i_inc && !i_clear && w_atMax;

    // Count register; only moves when the caller signals an increment or clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA stream receiver: recovers pixel coordinates and colour from hs/vs/RGB,
// checks line and frame periods, and reports lock after clean frames.
module vga_sync_receiver
    import vga_rx_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_START     = DEF_H_START,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_START     = DEF_V_START,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       pixel_en,
    input  logic       hs,
    input  logic       vs,
    input  logic [3:0] Red,
    input  logic [3:0] Green,
    input  logic [3:0] Blue,
    output logic       locked,
    output logic       pix_valid,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic [3:0] RedOut,
    output logic [3:0] GreenOut,
    output logic [3:0] BlueOut,
    output logic       frame_start,
    output logic       sync_err
);

    localparam coord_t     H_LO   = coord_t'(H_START);
    localparam coord_t     H_HI   = coord_t'(H_START + H_ACTIVE);
    localparam coord_t     V_LO   = coord_t'(V_START);
    localparam coord_t     V_HI   = coord_t'(V_START + V_ACTIVE);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    logic       r_hsPrev;
    logic       r_vsPrev;
    logic       r_vsPending;
    logic       w_hsFall;
    logic       w_vsFall;
    logic       w_vsConsume;

    coord_t     w_hCount;
    coord_t     w_vCount;
    logic       w_lineErr;
    logic       w_frameErr;
    logic       w_hSat;
    logic       w_vSat;
    logic       w_err;

    rxState_t   r_state;
    rxState_t   w_nextState;
    logic [3:0] r_good;
    logic [3:0] w_nextGood;
    logic       r_dirty;
    logic       w_nextDirty;
    logic       w_syncErr;

    logic       w_active;
    logic       w_pixel;
    coord_t     w_drawX;
    coord_t     w_drawY;

    logic       r_pixValid;
    logic       r_frameStart;
    logic       r_syncErr;
    coord_t     r_drawX;
    coord_t     r_drawY;
    logic [3:0] r_red;
    logic [3:0] r_green;
    logic [3:0] r_blue;

    // A vs edge on the same strobe as an hs edge counts as already pending.
    assign w_hsFall    = pixel_en && !hs && r_hsPrev;
    assign w_vsFall    = pixel_en && !vs && r_vsPrev;
    assign w_vsConsume = w_hsFall && (r_vsPending || w_vsFall);

    // Sync history and pending-frame flag, updated only on strobes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hsPrev    <= 1'b1;
            r_vsPrev    <= 1'b1;
            r_vsPending <= 1'b0;
        end else if (pixel_en) begin
            r_hsPrev <= hs;
            r_vsPrev <= vs;
            if (w_vsConsume) begin
                r_vsPending <= 1'b0;
            end else if (w_vsFall) begin
                r_vsPending <= 1'b1;
            end
        end
    end

    vga_period_counter #(
        .PERIOD (H_TOTAL)
    ) u_hCounter (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_inc      (pixel_en),
        .i_clear    (w_hsFall),
        .o_count    (w_hCount),
        .o_mismatch (w_lineErr),
        .o_sat      (w_hSat)
    );

    vga_period_counter #(
        .PERIOD (V_TOTAL)
    ) u_vCounter (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_inc      (w_hsFall),
        .i_clear    (w_vsConsume),
        .o_count    (w_vCount),
        .o_mismatch (w_frameErr),
        .o_sat      (w_vSat)
    );

    assign w_err = w_lineErr || w_frameErr || w_hSat || w_vSat;

    // Lock state, clean-frame tally and per-frame error memory.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= SEARCH;
            r_good  <= '0;
            r_dirty <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_good  <= w_nextGood;
            r_dirty <= w_nextDirty;
        end
    end

    // Next-state logic: errors are ignored while searching, reset the tally
    // while aligning, and drop lock immediately once locked.
    always_comb begin
        w_nextState = r_state;
        w_nextGood  = r_good;
        w_nextDirty = r_dirty;
        w_syncErr   = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_vsConsume) begin
                    w_nextState = ALIGN;
                    w_nextGood  = '0;
                    w_nextDirty = 1'b0;
                end
            end
            ALIGN: begin
                if (w_err) begin
                    w_syncErr   = 1'b1;
                    w_nextGood  = '0;
                    w_nextDirty = 1'b1;
                end
                if (w_vsConsume) begin
                    w_nextDirty = 1'b0;
                    if (!w_err && !r_dirty) begin
                        w_nextGood = r_good + 4'd1;
                        if ((r_good + 4'd1) == LOCK_N) begin
                            w_nextState = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (w_err) begin
                    w_syncErr   = 1'b1;
                    w_nextState = SEARCH;
                end
            end
            default: begin
                w_nextState = SEARCH;
            end
        endcase
    end

    assign w_active = (w_hCount >= H_LO) && (w_hCount < H_HI) &&
                      (w_vCount >= V_LO) && (w_vCount < V_HI);
    assign w_pixel  = pixel_en && (r_state == LOCKED) && w_active;
    assign w_drawX  = w_hCount - H_LO;
    assign w_drawY  = w_vCount - V_LO;

    // Registered pixel outputs; coordinates and colour hold between pixels.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pixValid   <= 1'b0;
            r_frameStart <= 1'b0;
            r_syncErr    <= 1'b0;
            r_drawX      <= '0;
            r_drawY      <= '0;
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
        end else begin
            r_pixValid   <= w_pixel;
            r_frameStart <= w_pixel && (w_drawX == '0) && (w_drawY == '0);
            r_syncErr    <= w_syncErr;
            if (w_pixel) begin
                r_drawX <= w_drawX;
                r_drawY <= w_drawY;
                r_red   <= Red;
                r_green <= Green;
                r_blue  <= Blue;
            end
        end
    end

    assign locked      = (r_state == LOCKED);
    assign pix_valid   = r_pixValid;
    assign frame_start = r_frameStart;
    assign sync_err    = r_syncErr;
    assign DrawX       = r_drawX;
    assign DrawY       = r_drawY;
    assign RedOut      = r_red;
    assign GreenOut    = r_green;
    assign BlueOut     = r_blue;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver using a reduced timing so whole frames are cheap.
module tb_vga_sync_receiver;

    localparam int H_TOTAL  = 40;
    localparam int H_START  = 8;
    localparam int H_ACTIVE = 24;
    localparam int V_TOTAL  = 20;
    localparam int V_START  = 3;
    localparam int V_ACTIVE = 12;
    localparam int LOCK_N   = 2;
    localparam int HSYNC    = 4;

    localparam int M_SEARCH = 0;
    localparam int M_ALIGN  = 1;
    localparam int M_LOCKED = 2;

    logic       Clk;
    logic       Reset;
    logic       pixel_en;
    logic       hs;
    logic       vs;
    logic [3:0] Red;
    logic [3:0] Green;
    logic [3:0] Blue;
    logic       locked;
    logic       pix_valid;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [3:0] RedOut;
    logic [3:0] GreenOut;
    logic [3:0] BlueOut;
    logic       frame_start;
    logic       sync_err;

    int errors = 0;
    int checks = 0;
    bit checkEn = 0;

    int pixCount = 0;
    int errCount = 0;
    bit fsSeen = 0;
    int fsX = -1;
    int fsY = -1;

    // Reference model state (plain integers, updated per strobe)
    int   mH, mV, mMode, mGood;
    bit   mHsPrev, mVsPrev, mVsPend, mFrameErr;
    bit   eValid, eFs, eErr;
    logic [9:0] eX, eY;
    logic [3:0] eR, eG, eB;

    vga_sync_receiver #(
        .H_TOTAL     (H_TOTAL),
        .H_START     (H_START),
        .H_ACTIVE    (H_ACTIVE),
        .V_TOTAL     (V_TOTAL),
        .V_START     (V_START),
        .V_ACTIVE    (V_ACTIVE),
        .LOCK_FRAMES (LOCK_N)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pixel_en    (pixel_en),
        .hs          (hs),
        .vs          (vs),
        .Red         (Red),
        .Green       (Green),
        .Blue        (Blue),
        .locked      (locked),
        .pix_valid   (pix_valid),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .RedOut      (RedOut),
        .GreenOut    (GreenOut),
        .BlueOut     (BlueOut),
        .frame_start (frame_start),
        .sync_err    (sync_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic mReset();
        mH = 0; mV = 0; mMode = M_SEARCH; mGood = 0;
        mHsPrev = 1; mVsPrev = 1; mVsPend = 0; mFrameErr = 0;
        eValid = 0; eFs = 0; eErr = 0;
        eX = '0; eY = '0; eR = '0; eG = '0; eB = '0;
    endtask

    // One strobe of the reference: counters from sync edges, then lock rules.
    task automatic mStep();
        bit hsFall, vsFall, consume, err;
        hsFall = !hs && mHsPrev;
        vsFall = !vs && mVsPrev;
        mHsPrev = hs;
        mVsPrev = vs;
        consume = hsFall && (mVsPend || vsFall);
        if (consume) mVsPend = 0;
        else if (vsFall) mVsPend = 1;
        err = 0;
        if (hsFall) begin
            if (mH + 1 != H_TOTAL) err = 1;
            mH = 0;
        end else if (mH == 1023) err = 1;
        else mH = mH + 1;
        if (hsFall) begin
            if (consume) begin
                if (mV + 1 != V_TOTAL) err = 1;
                mV = 0;
            end else if (mV == 1023) err = 1;
            else mV = mV + 1;
        end
        eValid = 0; eFs = 0; eErr = 0;
        if (mMode == M_LOCKED && mH >= H_START && mH < H_START + H_ACTIVE &&
            mV >= V_START && mV < V_START + V_ACTIVE) begin
            eValid = 1;
            eX = 10'(mH - H_START);
            eY = 10'(mV - V_START);
            eR = Red; eG = Green; eB = Blue;
            eFs = (mH == H_START) && (mV == V_START);
        end
        if (mMode == M_SEARCH) begin
            if (consume) begin
                mMode = M_ALIGN; mGood = 0; mFrameErr = 0;
            end
        end else if (mMode == M_ALIGN) begin
            if (err) begin
                eErr = 1; mGood = 0; mFrameErr = 1;
            end
            if (consume) begin
                if (!mFrameErr) begin
                    mGood = mGood + 1;
                    if (mGood == LOCK_N) mMode = M_LOCKED;
                end
                mFrameErr = 0;
            end
        end else begin
            if (err) begin
                eErr = 1; mMode = M_SEARCH;
            end
        end
    endtask

    // Reference model follows every clock edge and asynchronous reset.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) mReset();
        else if (pixel_en) mStep();
        else begin
            eValid = 0; eFs = 0; eErr = 0;
        end
    end

    // Compare DUT outputs against the model away from the active edge.
    always @(negedge Clk) begin
        if (checkEn) begin
            checks++;
            if (locked !== (mMode == M_LOCKED) || pix_valid !== eValid ||
                frame_start !== eFs || sync_err !== eErr || DrawX !== eX ||
                DrawY !== eY || RedOut !== eR || GreenOut !== eG || BlueOut !== eB) begin
                errors++;
                $display("[TB] FAIL model t=%0t got lk=%b pv=%b fs=%b se=%b x=%0d y=%0d rgb=%h%h%h required lk=%b pv=%b fs=%b se=%b x=%0d y=%0d rgb=%h%h%h",
                         $time, locked, pix_valid, frame_start, sync_err, DrawX, DrawY,
                         RedOut, GreenOut, BlueOut, (mMode == M_LOCKED), eValid, eFs,
                         eErr, eX, eY, eR, eG, eB);
            end
        end
    end

    // Event tallies used by the hand-computed checks.
    always @(negedge Clk) begin
        if (pix_valid === 1'b1) pixCount++;
        if (sync_err === 1'b1) errCount++;
        if (frame_start === 1'b1 && !fsSeen) begin
            fsSeen = 1;
            fsX = int'(DrawX);
            fsY = int'(DrawY);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic v, input logic [3:0] r,
                                 input logic [3:0] g, input logic [3:0] b, input int gap);
        repeat (gap) begin
            @(negedge Clk);
            pixel_en = 1'b0;
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            Red = 4'($urandom_range(0, 15));
            Green = 4'($urandom_range(0, 15));
            Blue = 4'($urandom_range(0, 15));
        end
        @(negedge Clk);
        pixel_en = 1'b1;
        hs = h;
        vs = v;
        Red = r;
        Green = g;
        Blue = b;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Locked"}, int'(locked), 0);
        checkOutput({tag, "PixValid"}, int'(pix_valid), 0);
        checkOutput({tag, "FrameStart"}, int'(frame_start), 0);
        checkOutput({tag, "SyncErr"}, int'(sync_err), 0);
        checkOutput({tag, "DrawX"}, int'(DrawX), 0);
        checkOutput({tag, "DrawY"}, int'(DrawY), 0);
        checkOutput({tag, "Rgb"}, int'({RedOut, GreenOut, BlueOut}), 0);
    endtask

    task automatic pulseReset();
        @(negedge Clk);
        pixel_en = 1'b0;
        #2 Reset = 1'b1;
        #1 checkAllZero("midReset");
        @(negedge Clk);
        @(negedge Clk);
        #2 Reset = 1'b0;
    endtask

    task automatic pauseStrobes(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 0);
            pixel_en = 1'b0;
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic holdHsHigh(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end
    endtask

    // One frame; vs is consumed by the hs edge of frame line 1 in both vs styles.
    task automatic sendFrame(input bit sameStrobe, input int shortLine, input int resetLine,
                             input int pauseLine, input bit pinLast, input bit fixedGap);
        int len;
        logic hv, vv;
        logic [3:0] r, g, b;
        bit lastPix;
        for (int y = 0; y < V_TOTAL; y++) begin
            len = (y == shortLine) ? H_TOTAL - 1 : H_TOTAL;
            for (int s = 0; s < len; s++) begin
                if (y == resetLine && s == 20) pulseReset();
                if (y == pauseLine && s == 20) pauseStrobes(1000);
                hv = (s >= HSYNC);
                vv = !((y == 0 && s >= 10 && !sameStrobe) || y == 1 || y == 2);
                r = 4'($urandom_range(0, 15));
                g = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                lastPix = pinLast && (s == H_START + H_ACTIVE - 1) &&
                          (y == 1 + V_START + V_ACTIVE - 1);
                if (lastPix) begin
                    r = 4'hA; g = 4'hB; b = 4'hC;
                end
                applyStimulus(hv, vv, r, g, b, fixedGap ? 1 : $urandom_range(0, 2));
                if (lastPix) begin
                    @(posedge Clk);
                    #1;
                    checkOutput("lastPixValid", int'(pix_valid), 1);
                    checkOutput("lastPixX", int'(DrawX), H_ACTIVE - 1);
                    checkOutput("lastPixY", int'(DrawY), V_ACTIVE - 1);
                    checkOutput("lastPixRed", int'(RedOut), 10);
                    checkOutput("lastPixGreen", int'(GreenOut), 11);
                    checkOutput("lastPixBlue", int'(BlueOut), 12);
                end
            end
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int errBase;
        int pixBase;
        Reset = 1'b1;
        pixel_en = 1'b0;
        hs = 1'b1;
        vs = 1'b1;
        Red = '0;
        Green = '0;
        Blue = '0;
        @(posedge Clk);
        #1 checkEn = 1;
        checkAllZero("reset");
        @(negedge Clk);
        #2 Reset = 1'b0;

        $display("[TB] ideal stream, strobe every second clock");
        sendFrame(0, -1, -1, -1, 0, 1);
        sendFrame(0, -1, -1, -1, 0, 1);
        checkOutput("lockedAfterTwoBoundaries", int'(locked), 0);
        sendFrame(0, -1, -1, -1, 0, 1);
        checkOutput("lockedAfterThreeBoundaries", int'(locked), 1);
        checkOutput("firstFrameStartSeen", int'(fsSeen), 1);
        checkOutput("firstFrameStartX", fsX, 0);
        checkOutput("firstFrameStartY", fsY, 0);
        pixBase = pixCount;
        sendFrame(0, -1, -1, -1, 1, 1);
        checkOutput("pixPerFrame", pixCount - pixBase, H_ACTIVE * V_ACTIVE);

        $display("[TB] short line while locked");
        errBase = errCount;
        sendFrame(0, 8, -1, -1, 0, 0);
        checkOutput("shortLineSyncErr", errCount - errBase, 1);
        checkOutput("shortLineLocked", int'(locked), 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        checkOutput("relockNotYet", int'(locked), 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        checkOutput("relockAfterShortLine", int'(locked), 1);

        $display("[TB] vs and hs falling on the same strobe");
        errBase = errCount;
        sendFrame(1, -1, -1, -1, 0, 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        checkOutput("sameStrobeNoErr", errCount - errBase, 0);
        checkOutput("sameStrobeLocked", int'(locked), 1);

        $display("[TB] hs held high");
        errBase = errCount;
        pixBase = pixCount;
        holdHsHigh(1100);
        @(posedge Clk);
        #1;
        checkOutput("hsHighSyncErr", errCount - errBase, 1);
        checkOutput("hsHighLocked", int'(locked), 0);
        checkOutput("hsHighNoPixels", pixCount - pixBase, 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        checkOutput("hsHighRelockNotYet", int'(locked), 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        checkOutput("hsHighRelock", int'(locked), 1);

        $display("[TB] reset mid-frame");
        sendFrame(0, -1, 6, -1, 0, 0);
        checkOutput("afterResetLocked", int'(locked), 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        checkOutput("resetRelockNotYet", int'(locked), 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        checkOutput("resetRelock", int'(locked), 1);

        $display("[TB] strobe paused for 1000 clocks");
        errBase = errCount;
        sendFrame(0, -1, -1, 8, 0, 0);
        sendFrame(0, -1, -1, -1, 0, 0);
        checkOutput("pauseNoErr", errCount - errBase, 0);
        checkOutput("pauseLocked", int'(locked), 1);

        @(negedge Clk);
        pixel_en = 1'b0;
        repeat (4) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
